// File: rtl/sreg_addr_counter.sv
// Serial-load SRAM address register with auto-increment on bus transfers.
// Shifts the address in MSB first, latches it on the avr_sreg_en rising edge,
// then advances it on each inc_strobe from the bus FSM.
module sreg_addr_counter #(
    parameter int unsigned ADDR_WIDTH = 21,
    parameter int unsigned AUTO_INC   = 1
) (
    input  logic                  avr_clk,
    input  logic                  avr_reset,
    input  logic                  avr_si,
    input  logic                  avr_sreg_en,
    input  logic                  inc_strobe,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  addr_valid,
    output logic                  short_load,
    output logic                  wrapped
);

    localparam int unsigned    CNT_W   = $clog2(ADDR_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ADDR_WIDTH);

    typedef enum logic {
        ST_SHIFT = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  prev_en_q, prev_en_d;
    logic [ADDR_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] sram_addr_d;
    logic                  addr_valid_d;
    logic                  short_load_d;
    logic                  wrapped_d;
    logic                  load_c;
    logic                  drop_c;

    assign load_c = avr_sreg_en & ~prev_en_q;
    assign drop_c = ~avr_sreg_en & prev_en_q;

    // Next-state and datapath; load and run->shift edges take priority over the per-state work.
    always_comb begin
        state_d      = state_q;
        prev_en_d    = avr_sreg_en;
        shreg_d      = shreg_q;
        count_d      = count_q;
        sram_addr_d  = sram_addr;
        addr_valid_d = addr_valid;
        short_load_d = short_load;
        wrapped_d    = wrapped;

        if (load_c) begin
            sram_addr_d  = shreg_q;
            addr_valid_d = 1'b1;
            short_load_d = (count_q < CNT_MAX);
            wrapped_d    = 1'b0;
            state_d      = ST_RUN;
        end else if (drop_c) begin
            addr_valid_d = 1'b0;
            shreg_d      = '0;
            count_d      = '0;
            state_d      = ST_SHIFT;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (!avr_sreg_en) begin
                        shreg_d = {shreg_q[ADDR_WIDTH-2:0], avr_si};
                        if (count_q != CNT_MAX) begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (avr_sreg_en && (AUTO_INC != 0) && inc_strobe) begin
                        sram_addr_d = sram_addr + ADDR_WIDTH'(1);
                        if (&sram_addr) begin
                            wrapped_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_SHIFT;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge avr_clk) begin
        if (avr_reset) begin
            state_q    <= ST_SHIFT;
            prev_en_q  <= 1'b0;
            shreg_q    <= '0;
            count_q    <= '0;
            sram_addr  <= '0;
            addr_valid <= 1'b0;
            short_load <= 1'b0;
            wrapped    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_en_q  <= prev_en_d;
            shreg_q    <= shreg_d;
            count_q    <= count_d;
            sram_addr  <= sram_addr_d;
            addr_valid <= addr_valid_d;
            short_load <= short_load_d;
            wrapped    <= wrapped_d;
        end
    end

endmodule

// File: tb/tb_sreg_addr_counter.sv
// Bench for sreg_addr_counter: vector table, corner sequences and a random run,
// all checked every cycle against an arithmetic reference model.
module tb_sreg_addr_counter;

    localparam int unsigned W   = 21;
    localparam longint      MOD = longint'(1) << W;

    logic         avr_clk = 1'b0;
    logic         avr_reset = 1'b0;
    logic         avr_si = 1'b0;
    logic         avr_sreg_en = 1'b0;
    logic         inc_strobe = 1'b0;
    logic [W-1:0] sram_addr, sram_addr0;
    logic         addr_valid, short_load, wrapped;
    logic         addr_valid0, short_load0, wrapped0;

    always #5 avr_clk = ~avr_clk;

    sreg_addr_counter #(.ADDR_WIDTH(W), .AUTO_INC(1)) dut (
        .avr_clk(avr_clk), .avr_reset(avr_reset), .avr_si(avr_si),
        .avr_sreg_en(avr_sreg_en), .inc_strobe(inc_strobe),
        .sram_addr(sram_addr), .addr_valid(addr_valid),
        .short_load(short_load), .wrapped(wrapped)
    );

    sreg_addr_counter #(.ADDR_WIDTH(W), .AUTO_INC(0)) dut0 (
        .avr_clk(avr_clk), .avr_reset(avr_reset), .avr_si(avr_si),
        .avr_sreg_en(avr_sreg_en), .inc_strobe(inc_strobe),
        .sram_addr(sram_addr0), .addr_valid(addr_valid0),
        .short_load(short_load0), .wrapped(wrapped0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the address as an integer, the shifted value modulo 2^W.
    longint m_sh = 0, m_addr = 0, m_addr0 = 0;
    int     m_cnt = 0;
    bit     m_valid = 0, m_short = 0, m_wrap = 0, m_prev = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (avr_reset) begin
            m_sh = 0; m_cnt = 0; m_addr = 0; m_addr0 = 0;
            m_valid = 0; m_short = 0; m_wrap = 0; m_prev = 0;
            return;
        end
        if (avr_sreg_en && !m_prev) begin
            m_addr  = m_sh;
            m_addr0 = m_sh;
            m_valid = 1;
            m_short = (m_cnt < int'(W));
            m_wrap  = 0;
        end else if (!avr_sreg_en && m_prev) begin
            m_valid = 0;
            m_sh    = 0;
            m_cnt   = 0;
        end else if (!avr_sreg_en) begin
            m_sh  = (m_sh * 2 + longint'(avr_si)) % MOD;
            m_cnt = (m_cnt < int'(W)) ? m_cnt + 1 : int'(W);
        end else if (inc_strobe) begin
            if (m_addr == MOD - 1) begin
                m_addr = 0;
                m_wrap = 1;
            end else begin
                m_addr = m_addr + 1;
            end
        end
        m_prev = avr_sreg_en;
    endtask

    // One clock: drive, advance the model at the edge, compare 1 time unit later.
    task automatic step(input bit rst, input bit en, input bit si, input bit stb);
        avr_reset   = rst;
        avr_sreg_en = en;
        avr_si      = si;
        inc_strobe  = stb;
        @(posedge avr_clk);
        model_edge();
        #1;
        check("model sram_addr",   longint'(sram_addr),   m_addr);
        check("model addr_valid",  longint'(addr_valid),  longint'(m_valid));
        check("model short_load",  longint'(short_load),  longint'(m_short));
        check("model wrapped",     longint'(wrapped),     longint'(m_wrap));
        check("noinc sram_addr",   longint'(sram_addr0),  m_addr0);
        check("noinc addr_valid",  longint'(addr_valid0), longint'(m_valid));
        check("noinc short_load",  longint'(short_load0), longint'(m_short));
        check("noinc wrapped",     longint'(wrapped0),    longint'(0));
    endtask

    // Shift nbits of val MSB first (dropping out of run first if needed), then load.
    task automatic load_value(input longint val, input int nbits, input bit stb_at_load);
        if (avr_sreg_en) step(1'b0, 1'b0, 1'($urandom), 1'b0);
        for (int i = nbits - 1; i >= 0; i--) begin
            step(1'b0, 1'b0, 1'((val >> i) & 1), 1'($urandom));
        end
        step(1'b0, 1'b1, 1'($urandom), stb_at_load);
    endtask

    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            step(1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    typedef struct {
        longint val;
        int     nbits;
        int     nstb;
        longint exp_addr;
        longint exp_addr0;
        bit     exp_short;
        bit     exp_wrap;
    } vec_t;

    vec_t vecs[9];

    initial begin
        bit en_r;

        vecs[0] = '{64'h012345, 21, 0, 64'h012345, 64'h012345, 1'b0, 1'b0};
        vecs[1] = '{64'h012345, 21, 5, 64'h01234A, 64'h012345, 1'b0, 1'b0};
        vecs[2] = '{64'h1FFFFE, 21, 1, 64'h1FFFFF, 64'h1FFFFE, 1'b0, 1'b0};
        vecs[3] = '{64'h1FFFFE, 21, 2, 64'h000000, 64'h1FFFFE, 1'b0, 1'b1};
        vecs[4] = '{64'h000010, 21, 0, 64'h000010, 64'h000010, 1'b0, 1'b0};
        vecs[5] = '{64'h004CCF, 15, 0, 64'h004CCF, 64'h004CCF, 1'b1, 1'b0};
        vecs[6] = '{64'h000000,  0, 0, 64'h000000, 64'h000000, 1'b1, 1'b0};
        vecs[7] = '{64'h1234567, 25, 1, 64'h034568, 64'h034567, 1'b0, 1'b0};
        vecs[8] = '{64'h1FFFFF, 21, 3, 64'h000002, 64'h1FFFFF, 1'b0, 1'b1};

        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset sram_addr",  longint'(sram_addr),  0);
        check("reset addr_valid", longint'(addr_valid), 0);
        check("reset short_load", longint'(short_load), 0);
        check("reset wrapped",    longint'(wrapped),    0);

        for (int v = 0; v < 9; v++) begin
            load_value(vecs[v].val, vecs[v].nbits, 1'b0);
            pulses(vecs[v].nstb);
            check($sformatf("vec%0d sram_addr", v),  longint'(sram_addr),  vecs[v].exp_addr);
            check($sformatf("vec%0d noinc addr", v), longint'(sram_addr0), vecs[v].exp_addr0);
            check($sformatf("vec%0d addr_valid", v), longint'(addr_valid), 1);
            check($sformatf("vec%0d short_load", v), longint'(short_load), longint'(vecs[v].exp_short));
            check($sformatf("vec%0d wrapped", v),    longint'(wrapped),    longint'(vecs[v].exp_wrap));
        end

        // Strobes with a back-to-back pair: 3 isolated + 2 adjacent.
        load_value(64'h012345, 21, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1); step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1); step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1); step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1); step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("pair sram_addr",  longint'(sram_addr),  64'h01234A);
        check("pair noinc addr", longint'(sram_addr0), 64'h012345);

        // Strobe coinciding with the load edge is dropped.
        load_value(64'h000100, 21, 1'b1);
        check("ldstb sram_addr", longint'(sram_addr), 64'h000100);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("ldstb next addr", longint'(sram_addr), 64'h000101);

        // Reset mid-shift discards partial bits.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'($urandom), 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check("midrst sram_addr",  longint'(sram_addr),  0);
        check("midrst addr_valid", longint'(addr_valid), 0);
        check("midrst short_load", longint'(short_load), 0);
        check("midrst wrapped",    longint'(wrapped),    0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        load_value(64'h0ABCDE, 21, 1'b0);
        check("midrst reload addr",  longint'(sram_addr),  64'h0ABCDE);
        check("midrst reload short", longint'(short_load), 0);
        check("midrst reload valid", longint'(addr_valid), 1);

        // Enable held high through reset: first edge after release loads zero.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("enrst sram_addr",  longint'(sram_addr),  0);
        check("enrst addr_valid", longint'(addr_valid), 1);
        check("enrst short_load", longint'(short_load), 1);

        // Random traffic against the model.
        en_r = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 11) == 0) en_r = ~en_r;
            step(($urandom_range(0, 199) == 0), en_r, 1'($urandom),
                 ($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
